npu_act_wr_arbiter: RTL and testbench
=====================================

NPU_ACT_WR_ARBITER -- requirements
Module: npu_act_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default `NPU_ACT_DATA_WIDTH, activation word width.
REQ-002 Parameter NUM_REQ, default 32, number of MAC-lane write requesters.
REQ-003 Parameter ADDR_WIDTH, default 12, activation memory address width.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 hw_mem_wr  input  NUM_REQ  per-lane write request level.
REQ-007 hw_mem_wr_addr  input  NUM_REQ*ADDR_WIDTH  per-lane address; lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 hw_mem_wr_data  input  NUM_REQ*DATA_WIDTH  per-lane data; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 npu_layer_in_progress  input  3  current layer ID from the NPU control unit.
REQ-010 hw_mem_wr_ack_p  output  NUM_REQ  one-hot one-cycle write-accepted pulse.
REQ-011 npu_act_mem_wr_en  output  1  activation memory write strobe.
REQ-012 npu_act_mem_wr_addr  output  ADDR_WIDTH  activation memory write address.
REQ-013 npu_act_mem_wr_data  output  DATA_WIDTH  activation memory write data.
REQ-014 arb_busy  output  1  high when any effective request is pending or a write is issuing.
REQ-015 act_wr_count  output  16  accepted-write counter (see Configuration).

Function
REQ-016 Effective request req_eff = hw_mem_wr & ~hw_mem_wr_ack_p. A lane acked this cycle is not eligible, so one request is never granted twice.
REQ-017 Each cycle with req_eff != 0, exactly one lane is granted: the lowest index i >= rr_ptr with req_eff[i] set, wrapping from NUM_REQ-1 to 0.
REQ-018 The grant is registered. On the next edge npu_act_mem_wr_en=1, addr/data are captured from the granted lane, and hw_mem_wr_ack_p has only the granted bit set, all in the same cycle. Latency from request to write is 1 cycle.
REQ-019 On a grant to lane g, rr_ptr becomes (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
REQ-020 With no grant, npu_act_mem_wr_en=0 and hw_mem_wr_ack_p=0. addr/data hold their last values.
REQ-021 Requesters hold the request level with stable addr/data until their ack, and may drop it or present a new request the cycle after.
REQ-022 Throughput: 1 write per cycle when at least 2 lanes request. A single lane requesting continuously is served at most every 2nd cycle.
REQ-023 A change of npu_layer_in_progress versus its registered copy resets rr_ptr to 0 at the next edge. Any grant in that same cycle still completes normally.
REQ-024 Fairness: with all lanes requesting continuously, every lane is acked exactly once per NUM_REQ consecutive writes.
REQ-025 arb_busy = (req_eff != 0) | npu_act_mem_wr_en.

Reset
REQ-026 While resetn=0, the following are forced asynchronously: npu_act_mem_wr_en=0, npu_act_mem_wr_addr=0, npu_act_mem_wr_data=0, hw_mem_wr_ack_p=0, rr_ptr=0, layer copy=0, act_wr_count=0.
REQ-027 Reset asserted mid-operation drops any pending grant without issuing a write. Unacked requesters are re-arbitrated from lane 0 after release.
REQ-028 The first grant is possible on the first clock edge after resetn deasserts.

Configuration
REQ-029 Macro NPU_ACT_ARB_CNT_EN. When defined, act_wr_count increments on every cycle with npu_act_mem_wr_en=1, saturates at 16'hFFFF, and clears on a layer change. A write in the clear cycle is not counted.
REQ-030 When NPU_ACT_ARB_CNT_EN is undefined, act_wr_count is tied to 16'h0000 and no counter flops are synthesised. The port list is unchanged.

Verification
REQ-031 Single request: lane 5 requests with addr 0x123 and data 0x00AB. The next cycle shows wr_en=1, addr=0x123, data=0x00AB and ack=32'h0000_0020. The cycle after shows wr_en=0.
REQ-032 All 32 lanes request from reset. Acks run lane 0,1,...,31 on 32 consecutive cycles, then bus idle. act_wr_count reads 32 with the macro defined and 0 without it.
REQ-033 Wrap: rr_ptr=30, requests on lanes 2 and 31. Lane 31 is acked first, then lane 2, then rr_ptr=3.
REQ-034 Lane 7 holds its request continuously. Acks occur on alternating cycles only, with no double ack for one request.
REQ-035 Layer change from 3'd1 to 3'd2 while rr_ptr=17, with all lanes requesting. The in-flight grant completes. The next grant goes to lane 0 and act_wr_count clears to 0.
REQ-036 resetn pulses low for 1 cycle while lanes 3 and 9 are pending. No write is issued during reset. After release lane 3 is acked, then lane 9.

Source files
------------

// File: rtl/npu_act_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ MAC-lane write requests onto one activation-memory write port.
// Optional accepted-write counter enabled by defining NPU_ACT_ARB_CNT_EN.

`ifndef NPU_ACT_DATA_WIDTH
`define NPU_ACT_DATA_WIDTH 16
`endif

module npu_act_wr_arbiter #(
    parameter int DATA_WIDTH = `NPU_ACT_DATA_WIDTH,
    parameter int NUM_REQ    = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            hw_mem_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] hw_mem_wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] hw_mem_wr_data,
    input  logic [2:0]                    npu_layer_in_progress,
    output logic [NUM_REQ-1:0]            hw_mem_wr_ack_p,
    output logic                          npu_act_mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         npu_act_mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         npu_act_mem_wr_data,
    output logic                          arb_busy,
    output logic [15:0]                   act_wr_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [2:0]            layer_q, layer_d;

    logic [NUM_REQ-1:0]    req_eff_s;
    logic                  grant_vld_s;
    logic [PTR_W-1:0]      grant_idx_s;
    logic                  layer_chg_s;

    // A lane acked this cycle is masked so one request is never granted twice.
    assign req_eff_s   = hw_mem_wr & ~ack_q;
    assign layer_chg_s = (npu_layer_in_progress != layer_q);

    // Rotating priority search: first requesting lane at or after rr_ptr, wrapping.
    always_comb begin
        logic [PTR_W:0] idx_s;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        idx_s       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (idx_s >= (PTR_W+1)'(NUM_REQ)) begin
                idx_s = idx_s - (PTR_W+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!grant_vld_s && req_eff_s[idx_s[PTR_W-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = idx_s[PTR_W-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Next-state for the write port, ack pulse and round-robin pointer.
    always_comb begin
        ack_d    = '0;
        wr_en_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        layer_d  = npu_layer_in_progress;
        if (grant_vld_s) begin
            ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
            wr_en_d = 1'b1;
            addr_d  = hw_mem_wr_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            data_d  = hw_mem_wr_data[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
            if (grant_idx_s == PTR_W'(NUM_REQ-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + PTR_W'(1);
            end
        end else begin
            ack_d   = '0;
            wr_en_d = 1'b0;
        end
        // A new layer restarts fairness at lane 0; an in-flight grant still issues.
        if (layer_chg_s) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = rr_ptr_d;
        end
    end

    // Arbiter state and registered write-port outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_q    <= '0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rr_ptr_q <= '0;
            layer_q  <= 3'd0;
        end else begin
            ack_q    <= ack_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
            layer_q  <= layer_d;
        end
    end

    assign hw_mem_wr_ack_p     = ack_q;
    assign npu_act_mem_wr_en   = wr_en_q;
    assign npu_act_mem_wr_addr = addr_q;
    assign npu_act_mem_wr_data = data_q;
    assign arb_busy            = (|req_eff_s) | wr_en_q;

`ifdef NPU_ACT_ARB_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating write counter; a layer change wins over a write in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (layer_chg_s) begin
            cnt_d = 16'h0000;
        end else if (wr_en_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign act_wr_count = cnt_q;
`else
    assign act_wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_npu_act_wr_arbiter.sv
// Directed and randomized bench for npu_act_wr_arbiter against a queue-free behavioural model.
// Honours NPU_ACT_ARB_CNT_EN for the expected counter value.

module tb_npu_act_wr_arbiter;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic [31:0]  req = 32'd0;
    logic [383:0] addr_bus;
    logic [511:0] data_bus;
    logic [2:0]   layer = 3'd0;
    logic [31:0]  ack;
    logic         wr_en;
    logic [11:0]  wr_addr;
    logic [15:0]  wr_data;
    logic         busy;
    logic [15:0]  cnt;

    logic [11:0]  a_arr [32];
    logic [15:0]  d_arr [32];

    int checks = 0;
    int errors = 0;

    // Behavioural model state: what the write port should show right now.
    logic [31:0]  m_ack;
    logic         m_wren;
    logic [11:0]  m_addr;
    logic [15:0]  m_data;
    int           m_ptr;
    logic [2:0]   m_layer;
    int           m_cnt;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 32; i++) begin : g_pack
        assign addr_bus[i*12 +: 12] = a_arr[i];
        assign data_bus[i*16 +: 16] = d_arr[i];
    end

    npu_act_wr_arbiter #(.DATA_WIDTH(16), .NUM_REQ(32), .ADDR_WIDTH(12)) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .hw_mem_wr             (req),
        .hw_mem_wr_addr        (addr_bus),
        .hw_mem_wr_data        (data_bus),
        .npu_layer_in_progress (layer),
        .hw_mem_wr_ack_p       (ack),
        .npu_act_mem_wr_en     (wr_en),
        .npu_act_mem_wr_addr   (wr_addr),
        .npu_act_mem_wr_data   (wr_data),
        .arb_busy              (busy),
        .act_wr_count          (cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [31:0] eff, input int ptr);
        for (int k = 0; k < 32; k++) begin
            if (eff[(ptr + k) % 32]) return (ptr + k) % 32;
        end
        return -1;
    endfunction

    function automatic int exp_cnt();
`ifdef NPU_ACT_ARB_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_ack = 32'd0; m_wren = 1'b0; m_addr = 12'd0; m_data = 16'd0;
        m_ptr = 0; m_layer = 3'd0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_ack"}, 64'(ack), 64'(m_ack));
        chk({tag, "_wren"}, 64'(wr_en), 64'(m_wren));
        chk({tag, "_addr"}, 64'(wr_addr), 64'(m_addr));
        chk({tag, "_data"}, 64'(wr_data), 64'(m_data));
        chk({tag, "_cnt"}, 64'(cnt), 64'(exp_cnt()));
    endtask

    // One clock cycle: check busy, predict the grant, clock, check the write port.
    task automatic step(input string tag);
        logic [31:0] eff;
        int          g;
        logic        chg;
        #1;
        eff = req & ~m_ack;
        chk({tag, "_busy"}, 64'(busy), 64'((eff != 32'd0) || m_wren));
        g   = pick(eff, m_ptr);
        chg = (layer != m_layer);
        @(posedge clk);
        #1;
        if (chg) m_cnt = 0;
        else if (m_wren && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (g >= 0) begin
            m_wren = 1'b1;
            m_ack  = 32'd1 << g;
            m_addr = a_arr[g];
            m_data = d_arr[g];
            m_ptr  = (g + 1) % 32;
        end else begin
            m_wren = 1'b0;
            m_ack  = 32'd0;
        end
        if (chg) m_ptr = 0;
        m_layer = layer;
        check_outputs(tag);
    endtask

    // Reset pulse spanning one rising edge, with the given lanes left requesting.
    task automatic do_reset(input logic [31:0] pending);
        req    = pending;
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_edge");
        resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            a_arr[i] = 12'(i * 3 + 1);
            d_arr[i] = 16'(16'h1000 + i);
        end
        model_reset();
        #2;
        do_reset(32'd0);

        // Single request on lane 5.
        a_arr[5] = 12'h123; d_arr[5] = 16'h00AB;
        req = 32'h0000_0020;
        step("t031");
        chk("t031_ack_c", 64'(ack), 64'h20);
        chk("t031_addr_c", 64'(wr_addr), 64'h123);
        chk("t031_data_c", 64'(wr_data), 64'hAB);
        chk("t031_wren_c", 64'(wr_en), 64'd1);
        req = 32'd0;
        step("t031b");
        chk("t031_idle_c", 64'(wr_en), 64'd0);

        // All lanes from reset: acks in lane order on consecutive cycles.
        do_reset(32'd0);
        for (int i = 0; i < 32; i++) begin
            a_arr[i] = 12'($urandom);
            d_arr[i] = 16'($urandom);
        end
        req = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            step("t032");
            chk("t032_order", 64'(ack), 64'(32'd1 << i));
            req = req & ~ack;
        end
        step("t032_idle");
        chk("t032_idle_c", 64'(wr_en), 64'd0);
`ifdef NPU_ACT_ARB_CNT_EN
        chk("t032_cnt_c", 64'(cnt), 64'd32);
`else
        chk("t032_cnt_c", 64'(cnt), 64'd0);
`endif

        // Wrap from pointer 30.
        req = 32'd1 << 29;
        step("t033a");
        chk("t033_l29", 64'(ack), 64'(32'd1 << 29));
        req = (32'd1 << 2) | (32'd1 << 31);
        step("t033b");
        chk("t033_l31", 64'(ack), 64'(32'd1 << 31));
        req = 32'd1 << 2;
        step("t033c");
        chk("t033_l2", 64'(ack), 64'(32'd1 << 2));
        req = (32'd1 << 1) | (32'd1 << 3);
        step("t033d");
        chk("t033_ptr3", 64'(ack), 64'(32'd1 << 3));
        req = 32'd1 << 1;
        step("t033e");
        chk("t033_l1", 64'(ack), 64'(32'd1 << 1));
        req = 32'd0;
        step("t033_idle");

        // Single lane held continuously: served every other cycle.
        req = 32'd1 << 7;
        for (int i = 0; i < 10; i++) begin
            step("t034");
            chk("t034_alt", 64'(ack), (i % 2 == 0) ? 64'(32'd1 << 7) : 64'd0);
        end
        req = 32'd0;
        step("t034_idle");
        step("t034_idle2");

        // Layer change while pointer sits at 17 with every lane requesting.
        layer = 3'd1;
        step("t035_l1");
        req = 32'd1 << 16;
        step("t035a");
        chk("t035_l16", 64'(ack), 64'(32'd1 << 16));
        req   = 32'hFFFF_FFFF;
        layer = 3'd2;
        step("t035b");
        chk("t035_inflight", 64'(ack), 64'(32'd1 << 17));
        chk("t035_cnt_clr", 64'(cnt), 64'd0);
        step("t035c");
        chk("t035_lane0", 64'(ack), 64'd1);
        req = 32'd0;
        step("t035_idle");
        step("t035_idle2");

        // Reset pulse while lanes 3 and 9 are pending.
        do_reset((32'd1 << 3) | (32'd1 << 9));
        step("t036a");
        chk("t036_l3", 64'(ack), 64'(32'd1 << 3));
        req = 32'd1 << 9;
        step("t036b");
        chk("t036_l9", 64'(ack), 64'(32'd1 << 9));
        req = 32'd0;
        step("t036_idle");

        // Randomized traffic with occasional layer changes.
        for (int c = 0; c < 600; c++) begin
            step("rnd");
            for (int i = 0; i < 32; i++) begin
                if (m_ack[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        a_arr[i] = 12'($urandom);
                        d_arr[i] = 16'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i]   = 1'b1;
                    a_arr[i] = 12'($urandom);
                    d_arr[i] = 16'($urandom);
                end
            end
            if ($urandom_range(29, 0) == 0) layer = 3'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
